// File: rtl/lbist_ctrl.sv
// lbist_ctrl: logic built-in self-test session controller.
//   A Galois LFSR (PRPG) issues one pseudo-random pattern per RUN cycle. The
//   circuit-under-test response, arriving RESP_LAT cycles later, is folded
//   into a MISR. After the last response the signature is compared against
//   GOLDEN_SIG and the verdict is held in DONE.
// Ports:
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   start_i         begin a session (IDLE/DONE only), num_pat_i sampled with it
//   seed_ld_i       load seed_i into the PRPG (IDLE/DONE only), zero -> PRPG_SEED
//   resp_i          circuit-under-test response
//   prn_o           PRPG register, pat_valid_o marks issued patterns
//   busy_o, done_o  session in progress / session finished
//   go_nogo_o       signature matched GOLDEN_SIG, sig_o current MISR value
module lbist_ctrl #(
  parameter int                PRPG_W     = 64,
  parameter logic [PRPG_W-1:0] PRPG_POLY  = 64'h000000000000001B,
  parameter logic [PRPG_W-1:0] PRPG_SEED  = {{(PRPG_W-1){1'b0}}, 1'b1},
  parameter int                MISR_W     = 32,
  parameter logic [MISR_W-1:0] MISR_POLY  = 32'h04C11DB7,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = {MISR_W{1'b0}},
  parameter int                CNT_W      = 16,
  parameter int                RESP_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_pat_i,
  input  logic              seed_ld_i,
  input  logic [PRPG_W-1:0] seed_i,
  input  logic [MISR_W-1:0] resp_i,
  output logic [PRPG_W-1:0] prn_o,
  output logic              pat_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              go_nogo_o,
  output logic [MISR_W-1:0] sig_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Last FLUSH count; meaningless (never reached) when RESP_LAT is zero.
  localparam logic [3:0]       FL_LAST  = 4'(RESP_LAT - 1);

  // One PRPG step: shift left, fold the polynomial back in on MSB carry-out.
  function automatic logic [PRPG_W-1:0] prpg_step(input logic [PRPG_W-1:0] s);
    logic [PRPG_W-1:0] fb;
    if (s[PRPG_W-1]) begin
      fb = PRPG_POLY;
    end else begin
      fb = {PRPG_W{1'b0}};
    end
    return {s[PRPG_W-2:0], 1'b0} ^ fb;
  endfunction

  // One MISR step: same LFSR update with the response XORed in.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [MISR_W-1:0] r);
    logic [MISR_W-1:0] fb;
    if (m[MISR_W-1]) begin
      fb = MISR_POLY;
    end else begin
      fb = {MISR_W{1'b0}};
    end
    return {m[MISR_W-2:0], 1'b0} ^ fb ^ r;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [PRPG_W-1:0] prpg_q, prpg_d;
  logic [MISR_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [3:0]        fl_q, fl_d;
  logic              pat_valid_q, pat_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              go_nogo_q, go_nogo_d;
  logic              cmp_en_s;

  // Response-alignment delay line: pat_valid delayed by RESP_LAT cycles
  // marks the cycles whose resp_i belongs to an issued pattern.
  generate
    if (RESP_LAT == 0) begin : g_no_dly
      assign cmp_en_s = pat_valid_q;
    end else begin : g_dly
      logic [RESP_LAT-1:0] dly_q, dly_d;

      // Shift pat_valid one stage per cycle.
      always_comb begin
        dly_d    = {RESP_LAT{1'b0}};
        dly_d[0] = pat_valid_q;
        for (int i = 1; i < RESP_LAT; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end

      // Delay line register.
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_q <= {RESP_LAT{1'b0}};
        end else begin
          dly_q <= dly_d;
        end
      end

      assign cmp_en_s = dly_q[RESP_LAT-1];
    end
  endgenerate

  // Session sequencing, PRPG/MISR next-state and output decode.
  always_comb begin
    state_d   = state_q;
    prpg_d    = prpg_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    fl_d      = fl_q;
    go_nogo_d = go_nogo_q;
    if (cmp_en_s) begin
      misr_d = misr_step(misr_q, resp_i);
    end else begin
      misr_d = misr_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // Seed load and start may coincide: the session then runs from the new seed.
        if (seed_ld_i) begin
          if (seed_i == {PRPG_W{1'b0}}) begin
            prpg_d = PRPG_SEED;
          end else begin
            prpg_d = seed_i;
          end
        end else begin
          prpg_d = prpg_q;
        end
        if (start_i) begin
          go_nogo_d = 1'b0;
          if (num_pat_i == CNT_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            misr_d  = {MISR_W{1'b0}};
            cnt_d   = CNT_ZERO;
            num_d   = num_pat_i;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        prpg_d = prpg_step(prpg_q);
        cnt_d  = cnt_q + CNT_ONE;
        // num_q is nonzero here, so num_q-1 never underflows.
        if (cnt_q == (num_q - CNT_ONE)) begin
          fl_d = 4'd0;
          if (RESP_LAT > 0) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_COMPARE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        fl_d = fl_q + 4'd1;
        if (fl_q == FL_LAST) begin
          state_d = S_COMPARE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_COMPARE: begin
        go_nogo_d = (misr_q == GOLDEN_SIG);
        state_d   = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pat_valid_d = (state_d == S_RUN);
    busy_d      = (state_d == S_RUN) || (state_d == S_FLUSH) || (state_d == S_COMPARE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prpg_q      <= PRPG_SEED;
      misr_q      <= {MISR_W{1'b0}};
      cnt_q       <= CNT_ZERO;
      num_q       <= CNT_ZERO;
      fl_q        <= 4'd0;
      pat_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      go_nogo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prpg_q      <= prpg_d;
      misr_q      <= misr_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      fl_q        <= fl_d;
      pat_valid_q <= pat_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      go_nogo_q   <= go_nogo_d;
    end
  end

  assign prn_o       = prpg_q;
  assign pat_valid_o = pat_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign go_nogo_o   = go_nogo_q;
  assign sig_o       = misr_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl: two instances (RESP_LAT 0 and 2) share stimulus.
// Expected patterns and session results are queued when a session starts;
// a negedge monitor pops and compares whenever the DUTs present outputs.
module tb_lbist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] num_pat_i;
  logic       seed_ld_i;
  logic [7:0] seed_i;
  logic [7:0] resp_i;

  logic [7:0] u0_prn, u1_prn, u0_sig, u1_sig;
  logic       u0_pv, u1_pv, u0_busy, u1_busy, u0_done, u1_done, u0_go, u1_go;

  always #5 clk = ~clk;

  lbist_ctrl #(.PRPG_W(8), .PRPG_POLY(8'h1D), .PRPG_SEED(8'h01), .MISR_W(8),
               .MISR_POLY(8'h1D), .GOLDEN_SIG(8'h04), .CNT_W(8), .RESP_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start_i(start_i), .num_pat_i(num_pat_i),
    .seed_ld_i(seed_ld_i), .seed_i(seed_i), .resp_i(resp_i), .prn_o(u0_prn),
    .pat_valid_o(u0_pv), .busy_o(u0_busy), .done_o(u0_done),
    .go_nogo_o(u0_go), .sig_o(u0_sig));

  lbist_ctrl #(.PRPG_W(8), .PRPG_POLY(8'h1D), .PRPG_SEED(8'h01), .MISR_W(8),
               .MISR_POLY(8'h1D), .GOLDEN_SIG(8'hA5), .CNT_W(8), .RESP_LAT(2)) u1 (
    .clk(clk), .rst(rst), .start_i(start_i), .num_pat_i(num_pat_i),
    .seed_ld_i(seed_ld_i), .seed_i(seed_i), .resp_i(resp_i), .prn_o(u1_prn),
    .pat_valid_o(u1_pv), .busy_o(u1_busy), .done_o(u1_done),
    .go_nogo_o(u1_go), .sig_o(u1_sig));

  typedef struct {
    int sig;
    int go;
    bit has_sig;
    int cyc;
  } res_t;

  logic [7:0] q_pat[$];
  res_t       q_res0[$];
  res_t       q_res1[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int model_prpg;
  int r_tab[0:299];
  res_t last0, last1;
  bit d0_prev = 1'b0;
  bit d1_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Multiply by x modulo x^8 + poly (GF(2) polynomial arithmetic on ints).
  function automatic int gf_x(input int v, input int poly);
    int t;
    t = v * 2;
    if (t >= 256) t = (t - 256) ^ poly;
    return t;
  endfunction

  // Monitor: compare issued patterns and session results as they appear.
  always @(negedge clk) begin
    if (!rst) begin
      if (u0_pv || u1_pv) begin
        if (q_pat.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pattern: got prn %0h with nothing expected", u0_prn);
        end else begin
          logic [7:0] e;
          e = q_pat.pop_front();
          chk("prn_u0", 32'(u0_prn), 32'(e));
          chk("prn_u1", 32'(u1_prn), 32'(e));
          chk("pat_valid_pair", {30'd0, u0_pv, u1_pv}, 32'd3);
        end
      end
      if (u0_done && !d0_prev) begin
        if (q_res0.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done_u0: got done with no session expected");
        end else begin
          res_t e;
          e = q_res0.pop_front();
          chk("done_cycle_u0", cyc, e.cyc);
          chk("go_nogo_u0", 32'(u0_go), e.go);
          if (e.has_sig) chk("sig_u0", 32'(u0_sig), e.sig);
        end
      end
      if (u1_done && !d1_prev) begin
        if (q_res1.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done_u1: got done with no session expected");
        end else begin
          res_t e;
          e = q_res1.pop_front();
          chk("done_cycle_u1", cyc, e.cyc);
          chk("go_nogo_u1", 32'(u1_go), e.go);
          if (e.has_sig) chk("sig_u1", 32'(u1_sig), e.sig);
        end
      end
    end
    d0_prev = u0_done;
    d1_prev = u1_done;
  end

  task automatic check_reset(input string nm);
    chk({nm, "_prn"}, {16'd0, u0_prn, u1_prn}, 32'h0101);
    chk({nm, "_sig"}, {16'd0, u0_sig, u1_sig}, 32'h0);
    chk({nm, "_flags"}, {24'd0, u0_pv, u1_pv, u0_busy, u1_busy, u0_done, u1_done, u0_go, u1_go}, 32'h0);
  endtask

  // Queue expectations and drive start for one session (at a negedge).
  task automatic start_sess(input int n, input bit ld, input int sd, input bit prn_resp);
    int s, m0, m1;
    @(negedge clk);
    if (ld) model_prpg = (sd == 0) ? 1 : sd;
    s = model_prpg;
    for (int c = 0; c < n + 8; c++) begin
      if (prn_resp && c < n) r_tab[c] = s;
      else r_tab[c] = int'($urandom_range(0, 255));
      if (c < n) begin
        q_pat.push_back(s[7:0]);
        s = gf_x(s, 'h1D);
      end
    end
    model_prpg = s;
    m0 = 0;
    m1 = 0;
    for (int k = 0; k < n; k++) begin
      m0 = gf_x(m0, 'h1D) ^ r_tab[k];
      m1 = gf_x(m1, 'h1D) ^ r_tab[k + 2];
    end
    last0.sig = m0; last0.has_sig = (n > 0);
    last1.sig = m1; last1.has_sig = (n > 0);
    last0.go = (n > 0 && m0 == 'h04) ? 1 : 0;
    last1.go = (n > 0 && m1 == 'hA5) ? 1 : 0;
    last0.cyc = (n > 0) ? cyc + n + 0 + 2 : cyc + 1;
    last1.cyc = (n > 0) ? cyc + n + 2 + 2 : cyc + 1;
    q_res0.push_back(last0);
    q_res1.push_back(last1);
    start_i   = 1'b1;
    num_pat_i = 8'(n);
    seed_ld_i = ld;
    seed_i    = 8'(sd);
  endtask

  task automatic run_session(input int n, input bit ld, input int sd, input bit prn_resp,
                             input bit noise);
    start_sess(n, ld, sd, prn_resp);
    for (int c = 0; c < n + 6; c++) begin
      @(negedge clk);
      resp_i    = 8'(r_tab[c]);
      start_i   = 1'b0;
      seed_ld_i = 1'b0;
      if (noise && c < n - 1 && $urandom_range(0, 2) == 0) begin
        start_i   = 1'b1;
        seed_ld_i = 1'b1;
        seed_i    = 8'($urandom_range(0, 255));
        num_pat_i = 8'($urandom_range(0, 255));
      end
      if (c == 0 && n > 0) chk("busy_run", {30'd0, u0_busy, u1_busy}, 32'd3);
    end
    chk("held_done", {28'd0, u0_done, u1_done, u0_busy, u1_busy}, 32'hC);
    chk("held_go_u0", 32'(u0_go), last0.go);
    chk("held_go_u1", 32'(u1_go), last1.go);
    if (n > 0) begin
      chk("held_sig_u0", 32'(u0_sig), last0.sig);
      chk("held_sig_u1", 32'(u1_sig), last1.sig);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; num_pat_i = 8'd0; seed_ld_i = 1'b0;
    seed_i = 8'd0; resp_i = 8'd0;
    model_prpg = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    // Standalone seed loads, including the zero-seed guard.
    @(negedge clk); seed_ld_i = 1'b1; seed_i = 8'h5C;
    @(negedge clk); seed_ld_i = 1'b0;
    chk("seed_load", {16'd0, u0_prn, u1_prn}, 32'h5C5C);
    seed_ld_i = 1'b1; seed_i = 8'h00;
    @(negedge clk); seed_ld_i = 1'b0;
    chk("seed_zero", {16'd0, u0_prn, u1_prn}, 32'h0101);
    model_prpg = 1;

    run_session(9, 1'b1, 'h01, 1'b0, 1'b0);   // 01,02,...,80,1D
    run_session(3, 1'b1, 'h01, 1'b1, 1'b0);   // resp = prn
    chk("golden_sig_u0", 32'(u0_sig), 32'h04);
    chk("golden_go_u0", 32'(u0_go), 32'd1);
    run_session(4, 1'b0, 0, 1'b0, 1'b0);      // done 8 cycles after start on u1
    run_session(5, 1'b1, 'hC3, 1'b0, 1'b1);   // seed with start, ignored noise

    // Reset in the middle of a run.
    start_sess(20, 1'b0, 0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      resp_i = 8'(r_tab[c]); start_i = 1'b0; seed_ld_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_pat.delete(); q_res0.delete(); q_res1.delete();
    model_prpg = 1;
    check_reset("reset_mid_run");

    run_session(0, 1'b0, 0, 1'b0, 1'b0);      // zero patterns from IDLE
    run_session(6, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int sd;
      sd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      run_session(int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)), sd, 1'b0, 1'b1);
    end
    run_session(255, 1'b0, 0, 1'b0, 1'b0);   // maximum count

    repeat (3) @(negedge clk);
    chk("pattern_queue_drained", q_pat.size(), 32'd0);
    chk("result_queues_drained", q_res0.size() + q_res1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lbist_ctrl.md
LBIST_CTRL -- requirements
Module: lbist_ctrl

Interface
REQ-001 SHALL have parameter PRPG_W, default 64, meaning pattern generator (PRPG) width; legal range 8..128.
REQ-002 SHALL have parameter PRPG_POLY, default 64'h000000000000001B, meaning PRPG feedback polynomial with bit0 set.
REQ-003 SHALL have parameter PRPG_SEED, default 1, meaning PRPG reset value; nonzero.
REQ-004 SHALL have parameter MISR_W, default 32, meaning response compactor width; legal range 8..64.
REQ-005 SHALL have parameter MISR_POLY, default 32'h04C11DB7, meaning MISR feedback polynomial.
REQ-006 SHALL have parameter GOLDEN_SIG, default 0, meaning expected final signature.
REQ-007 SHALL have parameter CNT_W, default 16, meaning pattern counter width.
REQ-008 SHALL have parameter RESP_LAT, default 2, meaning cycles from pattern issue to response; legal range 0..8.
REQ-009 SHALL have port clk, input, 1, meaning single clock; all state updates on its rising edge.
REQ-010 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-011 SHALL have port start_i, input, 1, meaning begin a test session.
REQ-012 SHALL have port num_pat_i, input, CNT_W, meaning number of patterns, sampled with start_i.
REQ-013 SHALL have port seed_ld_i, input, 1, meaning load seed_i into PRPG.
REQ-014 SHALL have port seed_i, input, PRPG_W, meaning seed value.
REQ-015 SHALL have port resp_i, input, MISR_W, meaning circuit-under-test response.
REQ-016 SHALL have port prn_o, output, PRPG_W, meaning current PRPG state, driven straight from the register.
REQ-017 SHALL have port pat_valid_o, output, 1, meaning prn_o is an issued pattern.
REQ-018 SHALL have port busy_o, output, 1, meaning session in progress.
REQ-019 SHALL have port done_o, output, 1, meaning session finished, result valid.
REQ-020 SHALL have port go_nogo_o, output, 1, meaning 1 = signature matched GOLDEN_SIG.
REQ-021 SHALL have port sig_o, output, MISR_W, meaning current MISR signature.

Function
REQ-022 SHALL implement FSM states IDLE, RUN, FLUSH, COMPARE, DONE.
REQ-023 SHALL go IDLE/DONE -> RUN on start_i with num_pat_i != 0; at that edge clear MISR and counter; PRPG not reset.
REQ-024 SHALL go IDLE/DONE -> DONE on start_i with num_pat_i == 0, with go_nogo_o=0.
REQ-025 SHALL in RUN hold pat_valid_o=1, advance PRPG and count up each cycle, and after num_pat_i cycles go to FLUSH (RESP_LAT>0) or COMPARE (RESP_LAT=0).
REQ-026 SHALL stay in FLUSH exactly RESP_LAT cycles, then go to COMPARE; COMPARE lasts 1 cycle, then DONE.
REQ-027 SHALL update PRPG as next = (s<<1) ^ (s[PRPG_W-1] ? PRPG_POLY : 0), truncated to PRPG_W.
REQ-028 SHALL update MISR as next = (m<<1) ^ (m[MISR_W-1] ? MISR_POLY : 0) ^ resp_i, only in cycles where pat_valid_o delayed by RESP_LAT cycles (shift register) is 1.
REQ-029 SHALL thus compact exactly num_pat_i responses per session.
REQ-030 SHALL in COMPARE register go_nogo_o = (MISR == GOLDEN_SIG).
REQ-031 SHALL in DONE hold done_o=1 and hold go_nogo_o and sig_o until the next start_i or rst.
REQ-032 SHALL assert busy_o in RUN, FLUSH and COMPARE.
REQ-033 SHALL ignore start_i and seed_ld_i in RUN, FLUSH and COMPARE.
REQ-034 SHALL load seed_i into PRPG on seed_ld_i in IDLE/DONE; a zero seed_i loads PRPG_SEED instead (lockup guard).
REQ-035 SHALL give seed_ld_i priority over start_i, so the session starts from the new seed.
REQ-036 SHALL wrap no counter: num_pat_i up to 2^CNT_W-1 is legal.
REQ-037 SHALL assert done_o from cycle N+L+2 after start_i is sampled, where N = num_pat_i and L = RESP_LAT.

Reset
REQ-038 SHALL on rst (any state, including mid-session) go to IDLE with PRPG=PRPG_SEED, MISR=0, counter=0, delay line=0, pat_valid_o=busy_o=done_o=go_nogo_o=0; rst has priority over all inputs.

Verification
REQ-039 SHALL cover, with PRPG_W=8, PRPG_POLY=8'h1D, seed 8'h01, start num_pat=9 -> prn_o sequence 01,02,04,08,10,20,40,80,1D.
REQ-040 SHALL cover, with MISR_W=8, MISR_POLY=8'h1D, RESP_LAT=0, resp_i=prn_o, num_pat=3 -> sig_o=8'h04 and go_nogo_o=1 iff GOLDEN_SIG=8'h04.
REQ-041 SHALL cover RESP_LAT=2, num_pat=4 -> exactly 4 compaction cycles, done_o at cycle 8 after start.
REQ-042 SHALL cover start with num_pat=0 -> DONE next cycle, go_nogo_o=0.
REQ-043 SHALL cover seed_ld_i with seed_i=0 -> PRPG=PRPG_SEED; seed_ld_i during RUN -> no effect.
REQ-044 SHALL cover rst asserted mid-RUN -> next cycle IDLE with all outputs at reset values; a new start completes normally.
